plic_lite: RTL and testbench

//  Parametrised platform-level external interrupt controller feeding mip.MEIP.

---
 rtl/plic_lite_pkg.sv | 22 ++
 rtl/plic_lite_int_gateway.sv | 47 ++++
 rtl/plic_lite.sv | 95 +++++++++
 tb/tb_plic_lite.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/plic_lite_pkg.sv
// Shared register map, ID width and request struct for the plic_lite controller.
package plic_lite_pkg;
    localparam logic [7:0] PLIC_PRIO_BASE = 8'h00;  // PRIO[i] sits at base + 4*i, i >= 1
    localparam logic [7:0] PLIC_ENABLE    = 8'h80;
    localparam logic [7:0] PLIC_EDGE      = 8'h84;
    localparam logic [7:0] PLIC_THRESH    = 8'h88;
    localparam logic [7:0] PLIC_CLAIM     = 8'h8C;
    localparam logic [7:0] PLIC_PENDING   = 8'h90;
    localparam int         PLIC_ID_W      = 5;
    localparam logic [31:0] CAUSE_EXTERNAL_INTERRUPT = 32'h8000_000B;

    typedef struct packed {
        logic        we;
        logic        re;
        logic [7:0]  addr;
        logic [31:0] wdata;
    } plic_req_t;

    function automatic logic [7:0] prio_addr(input int id);
        return PLIC_PRIO_BASE + 8'(4 * id);
    endfunction
endpackage

// File: rtl/plic_lite_int_gateway.sv
// Per-source gateway: synchroniser, level/edge request capture and claim/complete bookkeeping.
module plic_lite_int_gateway #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic irq_in,
    input  logic edge_mode,
    input  logic claim,
    input  logic complete,
    output logic pending,
    output logic in_flight
);
    logic [SYNC_STAGES-1:0] sync;
    logic s, s_prev, rise, done, set, edge_hold;

    assign s    = sync[SYNC_STAGES-1];
    assign rise = s & ~s_prev;
    assign done = complete & in_flight;
    // A completion re-opens the gate in the same cycle for edges, one cycle later for levels.
    assign set  = edge_mode ? (rise & (~in_flight | done)) : (s & ~in_flight);

    always_ff @(posedge clk) begin
        if (reset) begin
            sync      <= '0;
            s_prev    <= 1'b0;
            pending   <= 1'b0;
            in_flight <= 1'b0;
            edge_hold <= 1'b0;
        end else begin
            sync[0] <= irq_in;
            for (int i = 1; i < SYNC_STAGES; i++) sync[i] <= sync[i-1];
            s_prev <= s;
            if (claim) begin
                pending   <= 1'b0;
                in_flight <= 1'b1;
            end else begin
                pending <= pending | set | (done & edge_hold);
                if (done) in_flight <= 1'b0;
            end
            if (done)
                edge_hold <= 1'b0;
            else if (edge_mode & rise & in_flight)
                edge_hold <= 1'b1;
        end
    end
endmodule

// File: rtl/plic_lite.sv
// Lightweight PLIC: register file, priority/threshold arbitration, claim/complete decode, MEIP flop.
module plic_lite
    import plic_lite_pkg::*;
#(
    parameter int NUM_SRC     = 8,
    parameter int PRIO_W      = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_SRC-1:0] irq_src,
    input  logic               reg_we,
    input  logic               reg_re,
    input  logic [7:0]         reg_addr,
    input  logic [31:0]        reg_wdata,
    output logic [31:0]        reg_rdata,
    output logic               meip
);
    plic_req_t                      req;
    logic [NUM_SRC:1][PRIO_W-1:0]   prio;
    logic [NUM_SRC:1]               enable, edge_mode, pending, in_flight, claim_vec, complete_vec;
    logic [PRIO_W-1:0]              thresh, best_prio;
    logic [PLIC_ID_W-1:0]           best_id;
    logic [31:0]                    rd_val;
    logic                           claim, complete, unused_req;

    assign req        = '{we: reg_we, re: reg_re, addr: reg_addr, wdata: reg_wdata};
    assign unused_req = ^req;
    assign claim      = req.re && (req.addr == PLIC_CLAIM);
    assign complete   = req.we && (req.addr == PLIC_CLAIM);

    for (genvar g = 1; g <= NUM_SRC; g++) begin : g_src
        assign claim_vec[g]    = claim && (best_id == PLIC_ID_W'(g));
        assign complete_vec[g] = complete && (req.wdata[PLIC_ID_W-1:0] == PLIC_ID_W'(g));
        plic_lite_int_gateway #(.SYNC_STAGES(SYNC_STAGES)) int_gateway (
            .clk       (clk),
            .reset     (reset),
            .irq_in    (irq_src[g-1]),
            .edge_mode (edge_mode[g]),
            .claim     (claim_vec[g]),
            .complete  (complete_vec[g]),
            .pending   (pending[g]),
            .in_flight (in_flight[g])
        );
    end

    // Ascending scan with strict '>' keeps the lowest ID on priority ties.
    always_comb begin
        best_id   = '0;
        best_prio = thresh;
        for (int i = 1; i <= NUM_SRC; i++)
            if (pending[i] && enable[i] && (prio[i] > best_prio)) begin
                best_id   = PLIC_ID_W'(i);
                best_prio = prio[i];
            end
    end

    always_comb begin
        rd_val = '0;
        for (int i = 1; i <= NUM_SRC; i++)
            if (req.addr == prio_addr(i)) rd_val[PRIO_W-1:0] = prio[i];
        case (req.addr)
            PLIC_ENABLE:  rd_val[NUM_SRC:1]   = enable;
            PLIC_EDGE:    rd_val[NUM_SRC:1]   = edge_mode;
            PLIC_THRESH:  rd_val[PRIO_W-1:0]  = thresh;
            PLIC_CLAIM:   rd_val[PLIC_ID_W-1:0] = best_id;
            PLIC_PENDING: rd_val[NUM_SRC:1]   = pending;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio      <= '0;
            enable    <= '0;
            edge_mode <= '0;
            thresh    <= '0;
            meip      <= 1'b0;
            reg_rdata <= '0;
        end else begin
            meip      <= (best_id != '0);
            reg_rdata <= req.re ? rd_val : '0;
            if (req.we) begin
                for (int i = 1; i <= NUM_SRC; i++)
                    if (req.addr == prio_addr(i)) prio[i] <= req.wdata[PRIO_W-1:0];
                case (req.addr)
                    PLIC_ENABLE: enable    <= req.wdata[NUM_SRC:1];
                    PLIC_EDGE:   edge_mode <= req.wdata[NUM_SRC:1];
                    PLIC_THRESH: thresh    <= req.wdata[PRIO_W-1:0];
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_plic_lite.sv
// Directed plus randomized bench for plic_lite with a cycle-level behavioural reference model.
module tb_plic_lite;
    localparam int N  = 8;
    localparam int PW = 3;
    localparam int SS = 2;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] irq = '0;
    logic         we = 1'b0, re = 1'b0;
    logic [7:0]   addr = '0;
    logic [31:0]  wdata = '0;
    logic [31:0]  rdata;
    logic         meip;

    int nchk = 0, nerr = 0;

    plic_lite #(.NUM_SRC(N), .PRIO_W(PW), .SYNC_STAGES(SS)) dut (
        .clk(clk), .reset(reset), .irq_src(irq), .reg_we(we), .reg_re(re),
        .reg_addr(addr), .reg_wdata(wdata), .reg_rdata(rdata), .meip(meip)
    );

    always #5 clk = ~clk;

    // Reference model state: delay line for the synchronised lines plus per-source flags.
    logic [N:1]  m_sync [SS];
    logic [N:1]  m_prev, m_pend, m_inf, m_hold, m_en, m_edge;
    int          m_prio [N+1];
    int          m_thr;
    logic        m_meip;
    logic [31:0] m_rdata;
    bit          m_chk_rd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < SS; i++) m_sync[i] = '0;
        m_prev = '0; m_pend = '0; m_inf = '0; m_hold = '0; m_en = '0; m_edge = '0;
        for (int i = 0; i <= N; i++) m_prio[i] = 0;
        m_thr = 0; m_meip = 1'b0; m_rdata = '0; m_chk_rd = 1'b0;
    endtask

    function automatic int m_best();
        int b = 0, bp = -1;
        for (int k = 1; k <= N; k++)
            if (m_pend[k] && m_en[k] && m_prio[k] > m_thr && m_prio[k] > bp) begin
                b = k; bp = m_prio[k];
            end
        return b;
    endfunction

    function automatic logic [31:0] m_regval(input int b);
        logic [31:0] v = '0;
        int idx = int'(addr[7:2]);
        if (addr[1:0] == 2'b00 && idx >= 1 && idx <= N) v = m_prio[idx];
        case (addr)
            8'h80: v = {m_en, 1'b0};
            8'h84: v = {m_edge, 1'b0};
            8'h88: v = m_thr;
            8'h8C: v = b;
            8'h90: v = {m_pend, 1'b0};
            default: ;
        endcase
        return v;
    endfunction

    task automatic model_step();
        int b, cid, idx;
        bit claim, comp, done;
        logic [N:1] s, rise, np, ni, nh;
        b     = m_best();
        s     = m_sync[SS-1];
        rise  = s & ~m_prev;
        claim = re && addr == 8'h8C;
        comp  = we && addr == 8'h8C;
        cid   = int'(wdata[4:0]);
        m_chk_rd = re;
        if (re) m_rdata = m_regval(b);
        np = m_pend; ni = m_inf; nh = m_hold;
        for (int k = 1; k <= N; k++) begin
            done = comp && cid == k && m_inf[k];
            if (m_edge[k]) begin
                if (rise[k] && (!m_inf[k] || done)) np[k] = 1'b1;
                else if (rise[k]) nh[k] = 1'b1;
            end else if (s[k] && !m_inf[k]) np[k] = 1'b1;
            if (done) begin
                ni[k] = 1'b0;
                if (m_hold[k]) np[k] = 1'b1;
                nh[k] = 1'b0;
            end
            if (claim && b == k) begin np[k] = 1'b0; ni[k] = 1'b1; end
        end
        m_pend = np; m_inf = ni; m_hold = nh;
        m_meip = (b != 0);
        m_prev = s;
        for (int i = SS-1; i > 0; i--) m_sync[i] = m_sync[i-1];
        m_sync[0] = irq;
        if (we) begin
            idx = int'(addr[7:2]);
            if (addr[1:0] == 2'b00 && idx >= 1 && idx <= N) m_prio[idx] = int'(wdata[PW-1:0]);
            case (addr)
                8'h80: m_en   = wdata[N:1];
                8'h84: m_edge = wdata[N:1];
                8'h88: m_thr  = int'(wdata[PW-1:0]);
                default: ;
            endcase
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk); #1;
        chk("meip_model", {31'b0, meip}, {31'b0, m_meip});
        if (m_chk_rd) chk("rdata_model", rdata, m_rdata);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1; we = 1'b0; re = 1'b0;
        @(posedge clk); #1;
        model_reset();
        reset = 1'b0;
        chk("reset_meip", {31'b0, meip}, 32'd0);
        chk("reset_rdata", rdata, 32'd0);
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d);
        we = 1'b1; addr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    task automatic rd(input logic [7:0] a, output logic [31:0] v);
        re = 1'b1; addr = a;
        tick();
        re = 1'b0;
        v = rdata;
    endtask

    task automatic rd_exp(input string tag, input logic [7:0] a, input logic [31:0] exp);
        logic [31:0] v;
        rd(a, v);
        chk(tag, v, exp);
    endtask

    task automatic pulse(input int bitn);
        irq[bitn] = 1'b1; tick();
        irq[bitn] = 1'b0; tick();
    endtask

    initial begin
        logic [7:0] alist [16];
        model_reset();
        for (int k = 0; k < 9; k++) alist[k] = 8'(4 * k);
        alist[9] = 8'h80; alist[10] = 8'h84; alist[11] = 8'h88; alist[12] = 8'h8C;
        alist[13] = 8'h90; alist[14] = 8'h94; alist[15] = 8'hFC;

        // 1: reset values, pending without enable never raises meip
        do_reset();
        for (int i = 1; i <= N; i++) rd_exp("reset_prio", 8'(4 * i), 32'd0);
        rd_exp("reset_enable", 8'h80, 0);
        rd_exp("reset_edge", 8'h84, 0);
        rd_exp("reset_thresh", 8'h88, 0);
        rd_exp("reset_claim", 8'h8C, 0);
        rd_exp("reset_pending", 8'h90, 0);
        irq = 8'hFF;
        idle(6);
        chk("disabled_meip", {31'b0, meip}, 0);
        rd_exp("disabled_pending", 8'h90, 32'h1FE);
        irq = '0;
        do_reset();

        // 2: level source 3, latency and re-request only after complete
        wr(8'h0C, 2); wr(8'h88, 1); wr(8'h80, 32'h08);
        irq[2] = 1'b1;
        idle(3);
        chk("lat_meip_c3", {31'b0, meip}, 0);
        tick();
        chk("lat_meip_c4", {31'b0, meip}, 1);
        rd_exp("claim_src3", 8'h8C, 3);
        idle(6);
        chk("held_no_repend", {31'b0, meip}, 0);
        wr(8'h8C, 3);
        idle(3);
        chk("repend_after_complete", {31'b0, meip}, 1);
        irq[2] = 1'b0;
        rd_exp("claim_src3_again", 8'h8C, 3);
        wr(8'h8C, 3);
        idle(4);
        chk("dropped_meip", {31'b0, meip}, 0);
        do_reset();

        // 3: priority ordering with lowest-ID tie break
        wr(8'h08, 4); wr(8'h14, 4); wr(8'h1C, 6); wr(8'h80, 32'hA4);
        irq = 8'h52;
        idle(5);
        rd_exp("order_1", 8'h8C, 7);
        rd_exp("order_2", 8'h8C, 2);
        rd_exp("order_3", 8'h8C, 5);
        rd_exp("order_4", 8'h8C, 0);
        irq = '0;
        idle(3);
        wr(8'h8C, 2); wr(8'h8C, 5); wr(8'h8C, 7);
        idle(3);
        chk("order_quiet", {31'b0, meip}, 0);
        do_reset();

        // 4: edge mode with one-deep edge_hold
        wr(8'h84, 32'h10); wr(8'h10, 1); wr(8'h80, 32'h10);
        pulse(3);
        idle(4);
        chk("edge_meip", {31'b0, meip}, 1);
        rd_exp("edge_claim1", 8'h8C, 4);
        pulse(3);
        idle(5);
        chk("edge_held_no_meip", {31'b0, meip}, 0);
        wr(8'h8C, 4);
        chk("edge_complete_c1", {31'b0, meip}, 0);
        tick();
        chk("edge_complete_c2", {31'b0, meip}, 1);
        rd_exp("edge_claim2", 8'h8C, 4);
        pulse(3); idle(4);
        pulse(3); idle(4);
        wr(8'h8C, 4);
        idle(2);
        chk("edge_hold_meip", {31'b0, meip}, 1);
        rd_exp("edge_claim3", 8'h8C, 4);
        wr(8'h8C, 4);
        idle(3);
        chk("edge_third_lost", {31'b0, meip}, 0);
        rd_exp("edge_pending_empty", 8'h90, 0);
        do_reset();

        // 5: threshold boundary and priority zero
        irq[0] = 1'b1;
        wr(8'h04, 5); wr(8'h88, 5); wr(8'h80, 32'h02);
        idle(5);
        chk("thresh_equal", {31'b0, meip}, 0);
        wr(8'h88, 4);
        tick();
        chk("thresh_below", {31'b0, meip}, 1);
        wr(8'h04, 0);
        tick();
        chk("prio_zero", {31'b0, meip}, 0);

        // 6: bogus completes, then reset mid-handshake
        wr(8'h04, 5);
        idle(2);
        rd_exp("claim_src1", 8'h8C, 1);
        wr(8'h8C, 0); wr(8'h8C, 9); wr(8'h8C, 2);
        rd_exp("bogus_pending", 8'h90, 0);
        rd_exp("bogus_claim", 8'h8C, 0);
        idle(2);
        chk("bogus_meip", {31'b0, meip}, 0);
        do_reset();
        rd_exp("postreset_pending", 8'h90, 0);
        idle(4);
        rd_exp("postreset_repend", 8'h90, 32'h02);
        irq = '0;
        do_reset();

        // randomized traffic against the model
        for (int c = 0; c < 1500; c++) begin
            if ($urandom_range(0, 3) == 0) irq = 8'($urandom);
            we = 1'b0; re = 1'b0;
            case ($urandom_range(0, 9))
                0, 1: begin
                    we = 1'b1; addr = alist[$urandom_range(0, 15)];
                    wdata = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 9));
                end
                2, 3, 4: begin
                    re = 1'b1; addr = alist[$urandom_range(0, 15)];
                end
                5: begin
                    re = 1'b1; addr = 8'h8C;
                end
                6: begin
                    we = 1'b1; addr = 8'h8C; wdata = 32'($urandom_range(0, 9));
                end
                default: ;
            endcase
            tick();
        end
        we = 1'b0; re = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end
endmodule
